// File: rtl/hdmi_pixel_gen.sv
// rtl/hdmi_pixel_gen.sv - HDMI-style pixel source with programmable target-pixel count
module hdmi_pixel_gen #(
  parameter int LGDIM   = 12,
  parameter int H_BLANK = 16,
  parameter int HSYNC_W = 4,
  parameter int V_BLANK = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic [9:0]  o_pix_r,
  output logic [9:0]  o_pix_g,
  output logic [9:0]  o_pix_b,
  output logic        o_de,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_frame
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_HBLANK = 2'd2;
  localparam logic [1:0] S_VBLANK = 2'd3;

  // One blanking counter serves both HBLANK and VBLANK, so size it for the longer one.
  localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BW   = $clog2(BMAX + 1);

  localparam logic [BW-1:0] HB_LAST = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] VB_LAST = BW'(V_BLANK - 1);
  localparam logic [BW-1:0] HS_LEN  = BW'(HSYNC_W);

  // Cycle qualifier is not needed: a strobe alone defines a transfer here.
  logic unused_cyc;
  assign unused_cyc = i_wb_cyc;

  // Live register file (Wishbone-visible)
  logic [29:0]       target_q, target_d;
  logic [29:0]       bg_q, bg_d;
  logic [31:0]       count_q, count_d;
  logic              enable_q, enable_d;
  logic [LGDIM-1:0]  width_q, width_d;
  logic [LGDIM-1:0]  height_q, height_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdata_q, rdata_d;

  // Per-frame shadow copies, latched only at frame start
  logic [29:0]       target_s_q, target_s_d;
  logic [29:0]       bg_s_q, bg_s_d;
  logic [31:0]       count_s_q, count_s_d;
  logic [LGDIM-1:0]  width_s_q, width_s_d;
  logic [LGDIM-1:0]  height_s_q, height_s_d;

  // Raster state
  logic [1:0]        state_q, state_d;
  logic [LGDIM-1:0]  hcount_q, hcount_d;
  logic [LGDIM-1:0]  line_q, line_d;
  logic [31:0]       pixidx_q, pixidx_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;

  // Registered video outputs
  logic [29:0]       pix_q, pix_d;
  logic              de_q, de_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              frame_q, frame_d;

  logic              can_start;
  logic [29:0]       pix_sel;

  // Register writes, ack pipeline and read-data mux (read data tracks the address every clock)
  always_comb begin
    target_d = target_q;
    bg_d     = bg_q;
    count_d  = count_q;
    enable_d = enable_q;
    width_d  = width_q;
    height_d = height_q;
    ack_d    = i_wb_stb;
    if (i_wb_stb && i_wb_we) begin
      case (i_wb_addr)
        2'd0: target_d = i_wb_data[29:0];
        2'd1: bg_d     = i_wb_data[29:0];
        2'd2: count_d  = i_wb_data;
        default: begin
          enable_d = i_wb_data[31];
          height_d = i_wb_data[LGDIM+15:16];
          width_d  = i_wb_data[LGDIM-1:0];
        end
      endcase
    end
    rdata_d = 32'd0;
    case (i_wb_addr)
      2'd0: rdata_d = {2'b00, target_q};
      2'd1: rdata_d = {2'b00, bg_q};
      2'd2: rdata_d = count_q;
      default: begin
        rdata_d[31]          = enable_q;
        rdata_d[LGDIM+15:16] = height_q;
        rdata_d[LGDIM-1:0]   = width_q;
      end
    endcase
  end

  // Register file state
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      target_q <= '0;
      bg_q     <= '0;
      count_q  <= '0;
      enable_q <= 1'b0;
      width_q  <= '0;
      height_q <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      target_q <= target_d;
      bg_q     <= bg_d;
      count_q  <= count_d;
      enable_q <= enable_d;
      width_q  <= width_d;
      height_q <= height_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

  assign can_start = enable_q && (width_q != '0) && (height_q != '0);

  // Raster sequencer; outputs are derived from the next state so they line up with the state register
  always_comb begin
    state_d    = state_q;
    hcount_d   = hcount_q;
    line_d     = line_q;
    pixidx_d   = pixidx_q;
    bcnt_d     = bcnt_q;
    target_s_d = target_s_q;
    bg_s_d     = bg_s_q;
    count_s_d  = count_s_q;
    width_s_d  = width_s_q;
    height_s_d = height_s_q;

    case (state_q)
      S_IDLE: begin
        if (can_start) begin
          state_d    = S_ACTIVE;
          hcount_d   = '0;
          line_d     = '0;
          pixidx_d   = '0;
          target_s_d = target_q;
          bg_s_d     = bg_q;
          count_s_d  = count_q;
          width_s_d  = width_q;
          height_s_d = height_q;
        end
      end
      S_ACTIVE: begin
        // Saturating index keeps "pixidx < COUNT" correct for any COUNT.
        pixidx_d = (pixidx_q == '1) ? pixidx_q : pixidx_q + 32'd1;
        if (hcount_q == width_s_q - LGDIM'(1)) begin
          state_d = S_HBLANK;
          bcnt_d  = '0;
        end else begin
          hcount_d = hcount_q + LGDIM'(1);
        end
      end
      S_HBLANK: begin
        if (bcnt_q == HB_LAST) begin
          if (line_q < height_s_q - LGDIM'(1)) begin
            state_d  = S_ACTIVE;
            line_d   = line_q + LGDIM'(1);
            hcount_d = '0;
          end else begin
            state_d = S_VBLANK;
            bcnt_d  = '0;
          end
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      default: begin
        if (bcnt_q == VB_LAST) begin
          if (can_start) begin
            state_d    = S_ACTIVE;
            hcount_d   = '0;
            line_d     = '0;
            pixidx_d   = '0;
            target_s_d = target_q;
            bg_s_d     = bg_q;
            count_s_d  = count_q;
            width_s_d  = width_q;
            height_s_d = height_q;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
    endcase

    pix_sel = (pixidx_d < count_s_d) ? target_s_d : bg_s_d;
    pix_d   = '0;
    de_d    = 1'b0;
    hsync_d = 1'b0;
    vsync_d = 1'b0;
    frame_d = 1'b0;
    case (state_d)
      S_ACTIVE: begin
        de_d    = 1'b1;
        pix_d   = pix_sel;
        frame_d = (line_d == '0) && (hcount_d == '0);
      end
      S_HBLANK: hsync_d = (bcnt_d < HS_LEN);
      S_VBLANK: vsync_d = 1'b1;
      default:  ;
    endcase
  end

  // Raster state and shadow registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      hcount_q   <= '0;
      line_q     <= '0;
      pixidx_q   <= '0;
      bcnt_q     <= '0;
      target_s_q <= '0;
      bg_s_q     <= '0;
      count_s_q  <= '0;
      width_s_q  <= '0;
      height_s_q <= '0;
    end else begin
      state_q    <= state_d;
      hcount_q   <= hcount_d;
      line_q     <= line_d;
      pixidx_q   <= pixidx_d;
      bcnt_q     <= bcnt_d;
      target_s_q <= target_s_d;
      bg_s_q     <= bg_s_d;
      count_s_q  <= count_s_d;
      width_s_q  <= width_s_d;
      height_s_q <= height_s_d;
    end
  end

  // Video output registers; reset clears them immediately
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pix_q   <= '0;
      de_q    <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      pix_q   <= pix_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      frame_q <= frame_d;
    end
  end

  assign o_wb_stall = 1'b0;
  assign o_wb_ack   = ack_q;
  assign o_wb_data  = rdata_q;
  assign o_pix_r    = pix_q[29:20];
  assign o_pix_g    = pix_q[19:10];
  assign o_pix_b    = pix_q[9:0];
  assign o_de       = de_q;
  assign o_hsync    = hsync_q;
  assign o_vsync    = vsync_q;
  assign o_frame    = frame_q;

endmodule

// File: tb/tb_hdmi_pixel_gen.sv
// tb/tb_hdmi_pixel_gen.sv - scoreboard bench for hdmi_pixel_gen
module tb_hdmi_pixel_gen;
  localparam int HB  = 2;
  localparam int HSW = 1;
  localparam int VB  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [1:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_stall, wb_ack;
  logic [31:0] wb_rdata;
  logic [9:0]  pix_r, pix_g, pix_b;
  logic        de, hsync, vsync, frame;

  always #5 clk = ~clk;

  hdmi_pixel_gen #(.LGDIM(12), .H_BLANK(HB), .HSYNC_W(HSW), .V_BLANK(VB)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
    .i_wb_addr(wb_addr), .i_wb_data(wb_wdata),
    .o_wb_stall(wb_stall), .o_wb_ack(wb_ack), .o_wb_data(wb_rdata),
    .o_pix_r(pix_r), .o_pix_g(pix_g), .o_pix_b(pix_b),
    .o_de(de), .o_hsync(hsync), .o_vsync(vsync), .o_frame(frame)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit          rd;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t     wb_q[$];
  logic [30:0] pix_q[$];

  logic [31:0] m_target, m_bg, m_count, m_ctrl;
  int  exp_period, exp_hs;
  int  run_id = 0, mon_run_id = -1;
  int  cyc = 0, last_frame_cyc = 0;
  int  hs_cnt = 0, hs_run = 0, vs_run = 0;
  bit  prev_stb = 0;
  bit  video_ignore = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] rd_expect(input logic [1:0] a);
    case (a)
      2'd0:    return m_target & 32'h3FFF_FFFF;
      2'd1:    return m_bg & 32'h3FFF_FFFF;
      2'd2:    return m_count;
      default: return m_ctrl & 32'h8FFF_0FFF;
    endcase
  endfunction

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_addr = a; wb_wdata = d;
    wb_q.push_back('{1'b0, 32'h0});
    case (a)
      2'd0:    m_target = d;
      2'd1:    m_bg = d;
      2'd2:    m_count = d;
      default: m_ctrl = d;
    endcase
    @(posedge clk); #1;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
  endtask

  task automatic wb_read(input logic [1:0] a);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = a; wb_wdata = $urandom;
    wb_q.push_back('{1'b1, rd_expect(a)});
    @(posedge clk); #1;
    wb_cyc = 0; wb_stb = 0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 4; a++) wb_read(2'(a));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Reference: pixel i of a frame is TARGET while i < COUNT, else BACKGROUND.
  task automatic push_frame(input int w, input int h, input logic [31:0] c);
    for (int i = 0; i < w * h; i++)
      pix_q.push_back({(i == 0), (32'(i) < c) ? m_target[29:0] : m_bg[29:0]});
  endtask

  task automatic wait_frame();
    bit got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (frame) got = 1;
    end
    check("frame_seen", got, 1);
  endtask

  task automatic check_idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("idle_outputs", {de, hsync, vsync, frame, pix_r, pix_g, pix_b}, 0);
    end
  endtask

  task automatic wait_idle();
    bit seen_vs = 0, done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (vsync) seen_vs = 1;
      else if (seen_vs) done = 1;
    end
    check("vblank_end", done, 1);
    check_idle(20);
    check("pix_queue_drained", pix_q.size(), 0);
  endtask

  task automatic run_video(input int w, input int h, input int n,
                           input logic [31:0] c1, input logic [31:0] c2);
    exp_period = h * (w + HB) + VB;
    exp_hs     = h * HSW;
    run_id++;
    wb_write(2'd2, c1);
    push_frame(w, h, c1);
    for (int f = 1; f < n; f++) push_frame(w, h, c2);
    wb_write(2'd3, 32'h8000_0000 | (32'(h) << 16) | 32'(w) | ($urandom & 32'h7000_F000));
    for (int f = 0; f < n; f++) begin
      wait_frame();
      @(posedge clk); #1;
      if (f == 0 && c2 != c1) wb_write(2'd2, c2);
      if (f == n - 1) wb_write(2'd3, (32'(h) << 16) | 32'(w));
    end
    wait_idle();
  endtask

  // Monitor: Wishbone ack/data scoreboard and video pixel/sync scoreboard
  always @(negedge clk) begin
    wb_exp_t e;
    logic [30:0] pe;
    cyc++;
    if (rst) begin
      prev_stb = 0;
      hs_run   = 0;
      vs_run   = 0;
    end else begin
      if (prev_stb || wb_ack) check("wb_ack_latency", wb_ack, prev_stb);
      if (wb_ack) begin
        if (wb_q.size() == 0) check("wb_ack_expected", {1'b0, wb_ack}, 2'b10);
        else begin
          e = wb_q.pop_front();
          if (e.rd) check("wb_rdata", wb_rdata, e.data);
        end
      end
      prev_stb = wb_stb;
      if (!video_ignore) begin
        if (de) begin
          if (pix_q.size() == 0) check("pixel", {1'b0, frame, pix_r, pix_g, pix_b}, 32'h8000_0000);
          else begin
            pe = pix_q.pop_front();
            check("pixel", {1'b0, frame, pix_r, pix_g, pix_b}, {1'b0, pe});
          end
        end else begin
          check("blank_pixel", {frame, pix_r, pix_g, pix_b}, 0);
        end
        if (hsync) begin
          hs_run++; hs_cnt++;
        end else if (hs_run != 0) begin
          check("hsync_width", hs_run, HSW); hs_run = 0;
        end
        if (vsync) vs_run++;
        else if (vs_run != 0) begin
          check("vsync_width", vs_run, VB); vs_run = 0;
        end
        if (frame) begin
          if (mon_run_id == run_id) begin
            check("frame_period", cyc - last_frame_cyc, exp_period);
            check("hsync_per_frame", hs_cnt, exp_hs);
          end
          mon_run_id     = run_id;
          last_frame_cyc = cyc;
          hs_cnt         = 0;
        end
      end
    end
  end

  initial begin
    int w, h;
    logic [31:0] c;
    rst = 1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_addr = 0; wb_wdata = 0;
    m_target = 0; m_bg = 0; m_count = 0; m_ctrl = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {wb_ack, wb_rdata, de, hsync, vsync, frame, pix_r, pix_g, pix_b}, 0);
    check("wb_stall", wb_stall, 0);
    rst = 0;
    read_all();

    // Register file with random data, enable left clear so video stays idle
    for (int r = 0; r < 2; r++) begin
      wb_write(2'd0, $urandom);
      wb_write(2'd1, $urandom);
      wb_write(2'd2, $urandom);
      wb_write(2'd3, $urandom & 32'h7FFF_FFFF);
      read_all();
    end
    check_idle(5);

    // Directed frames from the plan
    wb_write(2'd0, 32'h3FF0_0001);
    wb_write(2'd1, 32'h000F_FC00);
    run_video(4, 2, 3, 32'd3, 32'd3);
    run_video(4, 2, 2, 32'd100, 32'd100);
    run_video(4, 2, 2, 32'd0, 32'd0);
    run_video(4, 2, 2, 32'd3, 32'd5);

    // Random geometry, colours and counts
    for (int r = 0; r < 5; r++) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 3);
      c = 32'($urandom_range(0, w * h + 2));
      wb_write(2'd0, $urandom);
      wb_write(2'd1, $urandom);
      run_video(w, h, 2, c, c);
    end
    read_all();

    // Asynchronous reset in the middle of active video
    video_ignore = 1;
    wb_write(2'd3, 32'h8002_0004);
    wait_frame();
    @(negedge clk);
    check("pre_reset_de", de, 1);
    #2 rst = 1;
    #1 check("async_reset_outputs", {de, hsync, vsync, frame, pix_r, pix_g, pix_b, wb_ack}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    m_target = 0; m_bg = 0; m_count = 0; m_ctrl = 0;
    pix_q.delete();
    run_id++;
    video_ignore = 0;
    read_all();
    check_idle(40);
    check("wb_queue_drained", wb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
